// File: rtl/fft_mag_reader.sv
// fft_mag_reader: after FFT done, sweeps FFT memory and streams re^2+im^2 per bin through a 4-entry FWFT FIFO.
// Optional build macro FFT_MAG_BITREV_EN: memory is addressed bit-reversed so bins still leave in natural order.
module fft_mag_reader #(
  parameter int N_LOG2 = 11,
  parameter int MAG_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fft_done,
  input  logic              start,
  output logic [N_LOG2-1:0] fft_addr,
  input  logic [31:0]       fft_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAG_W-1:0]  out_mag,
  output logic [N_LOG2-1:0] out_index,
  output logic              out_last,
  output logic              frame_done,
  output logic [1:0]        state_dbg
);

  // Output handshake: a bin transfers on any rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_mag/out_index/out_last hold unchanged.

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t state, state_d;

  logic [N_LOG2-1:0] issue_k, k_cur;
  logic              rd_v1, rd_v2;
  logic [N_LOG2-1:0] idx1, idx2;
  logic [2:0]        fifo_cnt, occupancy;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [MAG_W-1:0]  mag_mem  [4];
  logic [N_LOG2-1:0] idx_mem  [4];
  logic              last_mem [4];

  logic start_ok, abort, can_issue, push, pop, last_pop;

  logic signed [15:0] re, im;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]        mag_sum;

  function automatic logic [N_LOG2-1:0] addr_map(input logic [N_LOG2-1:0] k);
    logic [N_LOG2-1:0] a;
`ifdef FFT_MAG_BITREV_EN
    for (int i = 0; i < N_LOG2; i++) a[i] = k[N_LOG2-1-i];
`else
    a = k;
`endif
    return a;
  endfunction

  // Largest sum is 2*(-32768)^2 = 2^31, so the unsigned 32-bit add never overflows.
  assign re      = fft_data[31:16];
  assign im      = fft_data[15:0];
  assign re_sq   = 32'(re) * 32'(re);
  assign im_sq   = 32'(im) * 32'(im);
  assign mag_sum = $unsigned(re_sq) + $unsigned(im_sq);

  assign start_ok  = (state == IDLE) && start && fft_done;
  assign abort     = (state != IDLE) && !fft_done;
  assign occupancy = fifo_cnt + 3'(rd_v1) + 3'(rd_v2);
  assign k_cur     = (state == IDLE) ? '0 : issue_k;
  assign can_issue = (start_ok || ((state == READ) && fft_done)) && (occupancy < 3'd4);
  assign push      = rd_v2;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && out_last;

  assign out_valid = (fifo_cnt != 3'd0);
  assign out_mag   = mag_mem[rd_ptr];
  assign out_index = idx_mem[rd_ptr];
  assign out_last  = last_mem[rd_ptr];
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start_ok) state_d = READ;
      READ: begin
        if (abort) state_d = IDLE;
        else if (can_issue && (k_cur == '1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      issue_k    <= '0;
      fft_addr   <= '0;
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      idx1       <= '0;
      idx2       <= '0;
      fifo_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mag_mem[i]  <= '0;
        idx_mem[i]  <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      state      <= state_d;
      frame_done <= (state == DRAIN) && !abort && last_pop;
      if (can_issue) begin
        fft_addr <= addr_map(k_cur);
        issue_k  <= k_cur + 1'b1;
      end
      // Stage 1: address on the BRAM; stage 2: fft_data valid, squared and pushed.
      rd_v1 <= can_issue;
      idx1  <= k_cur;
      rd_v2 <= rd_v1 && !abort;
      idx2  <= idx1;
      if (abort) begin
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (push) begin
          mag_mem[wr_ptr]  <= mag_sum[31 -: MAG_W];
          idx_mem[wr_ptr]  <= idx2;
          last_mem[wr_ptr] <= &idx2;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      end
    end
  end

endmodule
